// File: rtl/digit_gcd_unit.sv
// digit_gcd_unit: N_SLOTS mod-MOD digit accumulators edited through add/next
// buttons, with a multi-cycle subtractive Euclid engine that finds the GCD of
// all slots. data_out shows slot[select] in SETUP and slot[select]/gcd in SHOW.
// Optional build macro: DGCD_AUTO_CLEAR_EN clears all slots and the gcd on a
// SHOW->SETUP transition.
module digit_gcd_unit #(
    parameter int N_SLOTS = 2,
    parameter int MOD     = 10,
    parameter int W       = 4,
    parameter int SW      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] select,
    input  logic          add,
    input  logic          next,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_out,
    output logic          busy,
    output logic          gcd_ok
);

    typedef enum logic [1:0] {SETUP, CALC, SHOW} state_t;

    logic          rst_meta, rst_sync;
    logic          add_q, next_q;
    logic          add_p, next_p;
    state_t        state, state_nxt;
    logic [W-1:0]  slots     [N_SLOTS];
    logic [W-1:0]  slots_nxt [N_SLOTS];
    logic [W-1:0]  a, b, a_nxt, b_nxt;
    logic [SW-1:0] k, k_nxt;
    logic [W-1:0]  gcd, gcd_nxt;
    logic [W-1:0]  dout_nxt;
    logic [SW-1:0] sel;
    logic [W-1:0]  din_red;
    logic [W:0]    sum;
    logic [W-1:0]  res;
    logic          pair_done;

    // Reset synchroniser: assertion passes straight through, release waits two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Out-of-range select values alias to slot 0; addends are reduced mod MOD first.
    assign sel     = (int'(select) >= N_SLOTS) ? '0 : select;
    assign din_red = data_in % W'(MOD);
    assign add_p   = add & ~add_q;
    assign next_p  = next & ~next_q;
    assign busy    = (state == CALC);
    assign gcd_ok  = (state == SHOW);

    // Next-state logic: slot edits, Euclid stepping, mode changes and display value.
    always_comb begin
        state_nxt = state;
        slots_nxt = slots;
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        gcd_nxt   = gcd;
        dout_nxt  = data_out;
        sum       = '0;
        res       = a;
        pair_done = 1'b0;
        case (state)
            SETUP: begin
                if (add_p) begin
                    sum = {1'b0, slots[sel]} + {1'b0, din_red};
                    if (sum >= (W+1)'(MOD)) sum = sum - (W+1)'(MOD);
                    slots_nxt[sel] = sum[W-1:0];
                end
                // The add above lands first, so CALC starts from the updated slots.
                if (next_p) begin
                    state_nxt = CALC;
                    a_nxt     = slots_nxt[0];
                    b_nxt     = slots_nxt[1];
                    k_nxt     = SW'(1);
                end
            end
            CALC: begin
                if (next_p) begin
                    state_nxt = SETUP;
                end else begin
                    if (b == '0 || a == b) begin
                        pair_done = 1'b1;
                        res       = a;
                    end else if (a == '0) begin
                        pair_done = 1'b1;
                        res       = b;
                    end else if (a > b) begin
                        a_nxt = a - b;
                    end else begin
                        b_nxt = b - a;
                    end
                    if (pair_done) begin
                        if (k == SW'(N_SLOTS - 1)) begin
                            gcd_nxt   = res;
                            state_nxt = SHOW;
                        end else begin
                            a_nxt = res;
                            k_nxt = k + SW'(1);
                            b_nxt = slots[k + SW'(1)];
                        end
                    end
                end
            end
            SHOW: begin
                if (next_p) begin
                    state_nxt = SETUP;
`ifdef DGCD_AUTO_CLEAR_EN
                    for (int i = 0; i < N_SLOTS; i++) slots_nxt[i] = '0;
                    gcd_nxt = '0;
`endif
                end
            end
            default: state_nxt = SETUP;
        endcase
        // Display follows the state being entered; CALC keeps the last value.
        case (state_nxt)
            SETUP:   dout_nxt = slots_nxt[sel];
            SHOW:    dout_nxt = (gcd_nxt == '0) ? '0 : slots_nxt[sel] / gcd_nxt;
            default: dout_nxt = data_out;
        endcase
    end

    // State, datapath and display registers.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            add_q    <= 1'b0;
            next_q   <= 1'b0;
            state    <= SETUP;
            for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
            a        <= '0;
            b        <= '0;
            k        <= '0;
            gcd      <= '0;
            data_out <= '0;
        end else begin
            add_q    <= add;
            next_q   <= next;
            state    <= state_nxt;
            slots    <= slots_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
            k        <= k_nxt;
            gcd      <= gcd_nxt;
            data_out <= dout_nxt;
        end
    end

endmodule
